// File: rtl/stream_trim.sv
// Crops a raster-ordered IN_SIZE x IN_SIZE frame to an OUT_SIZE x OUT_SIZE window at a
// per-frame, clamped offset, presenting kept pixels through a one-deep registered output.
module stream_trim #(
  parameter int DATA_W   = 32,
  parameter int CHANNELS = 1,
  parameter int IN_SIZE  = 13,
  parameter int OUT_SIZE = 7,
  parameter int IDX_W    = $clog2(IN_SIZE)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [IDX_W-1:0]           row_off,
  input  logic [IDX_W-1:0]           col_off,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_W*CHANNELS-1:0] s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_W*CHANNELS-1:0] m_data,
  output logic                       m_row_end,
  output logic                       m_last,
  output logic                       busy,
  output logic                       cfg_err
);
  // One extra bit so that offset + OUT_SIZE never overflows in the window compare.
  localparam int XW = IDX_W + 1;
  localparam logic [XW-1:0]    MAX_OFF  = XW'(IN_SIZE - OUT_SIZE);
  localparam logic [XW-1:0]    OUT_LEN  = XW'(OUT_SIZE);
  localparam logic [XW-1:0]    ONE_X    = XW'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN_SIZE - 1);
  localparam logic [IDX_W-1:0] ONE_I    = IDX_W'(1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           in_row_q, in_row_d, in_col_q, in_col_d;
  logic [IDX_W-1:0]           lr_q, lr_d, lc_q, lc_d;
  logic                       m_valid_q, m_valid_d, m_row_end_q, m_row_end_d;
  logic                       m_last_q, m_last_d, busy_q, busy_d, cfg_err_q, cfg_err_d;
  logic [DATA_W*CHANNELS-1:0] m_data_q, m_data_d;

  logic          ready_s, accept_s, in_win_s, row_end_s, last_s, col_wrap_s, frame_end_s;
  logic [XW-1:0] row_clamp_s, col_clamp_s, lr_x_s, lc_x_s, row_x_s, col_x_s;

  function automatic logic [XW-1:0] clamp_off(input logic [IDX_W-1:0] off);
    logic [XW-1:0] off_x;
    off_x = {1'b0, off};
    if (off_x > MAX_OFF) begin
      return MAX_OFF;
    end else begin
      return off_x;
    end
  endfunction

  // Handshake, window test on the current beat, and next-state computation.
  always_comb begin
    ready_s     = en && (!m_valid_q || m_ready);
    accept_s    = s_valid && ready_s;
    row_clamp_s = clamp_off(row_off);
    col_clamp_s = clamp_off(col_off);
    // The first beat of a frame is judged against the offsets being latched with it.
    if (state_q == IDLE) begin
      lr_x_s = row_clamp_s;
      lc_x_s = col_clamp_s;
    end else begin
      lr_x_s = {1'b0, lr_q};
      lc_x_s = {1'b0, lc_q};
    end
    row_x_s     = {1'b0, in_row_q};
    col_x_s     = {1'b0, in_col_q};
    in_win_s    = (row_x_s >= lr_x_s) && (row_x_s < lr_x_s + OUT_LEN) &&
                  (col_x_s >= lc_x_s) && (col_x_s < lc_x_s + OUT_LEN);
    row_end_s   = (col_x_s == lc_x_s + OUT_LEN - ONE_X);
    last_s      = row_end_s && (row_x_s == lr_x_s + OUT_LEN - ONE_X);
    col_wrap_s  = (in_col_q == LAST_IDX);
    frame_end_s = col_wrap_s && (in_row_q == LAST_IDX);

    state_d     = state_q;
    in_row_d    = in_row_q;
    in_col_d    = in_col_q;
    lr_d        = lr_q;
    lc_d        = lc_q;
    cfg_err_d   = cfg_err_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_row_end_d = m_row_end_q;
    m_last_d    = m_last_q;

    if (accept_s) begin
      if (state_q == IDLE) begin
        lr_d      = lr_x_s[IDX_W-1:0];
        lc_d      = lc_x_s[IDX_W-1:0];
        cfg_err_d = cfg_err_q || ({1'b0, row_off} > MAX_OFF) || ({1'b0, col_off} > MAX_OFF);
      end else begin
        lr_d = lr_q;
      end
      if (col_wrap_s) begin
        in_col_d = '0;
        in_row_d = frame_end_s ? '0 : in_row_q + ONE_I;
      end else begin
        in_col_d = in_col_q + ONE_I;
      end
      state_d = frame_end_s ? IDLE : RUN;
    end else begin
      state_d = state_q;
    end

    if (accept_s && in_win_s) begin
      m_valid_d   = 1'b1;
      m_data_d    = s_data;
      m_row_end_d = row_end_s;
      m_last_d    = last_s;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end

    busy_d = (state_d == RUN);
  end

  // All state, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      in_row_q    <= '0;
      in_col_q    <= '0;
      lr_q        <= '0;
      lc_q        <= '0;
      cfg_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_row_end_q <= 1'b0;
      m_last_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_row_q    <= in_row_d;
      in_col_q    <= in_col_d;
      lr_q        <= lr_d;
      lc_q        <= lc_d;
      cfg_err_q   <= cfg_err_d;
      busy_q      <= busy_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_row_end_q <= m_row_end_d;
      m_last_q    <= m_last_d;
    end
  end

  assign s_ready   = ready_s;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_row_end = m_row_end_q;
  assign m_last    = m_last_q;
  assign busy      = busy_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_stream_trim.sv
// Self-checking bench for stream_trim: a frame-level model predicts every kept beat, and the
// output stream is compared against it each cycle and against hand-computed crop results.
module tb_stream_trim;
  localparam int DW   = 32;
  localparam int CH   = 1;
  localparam int IN   = 13;
  localparam int OUT  = 7;
  localparam int IW   = $clog2(IN);
  localparam int BW   = DW * CH;
  localparam int MAXO = IN - OUT;

  logic          clk = 1'b0;
  logic          reset, en, s_valid, m_ready;
  logic [IW-1:0] row_off, col_off;
  logic [BW-1:0] s_data;
  logic          s_ready, m_valid, m_row_end, m_last, busy, cfg_err;
  logic [BW-1:0] m_data;

  typedef struct { logic [BW-1:0] d; logic re; logic la; } beat_t;

  beat_t         exp_q[$];
  beat_t         out_log[$];
  logic [BW-1:0] frame_data [IN*IN];
  int            tests = 0;
  int            fails = 0;
  int            k = 0;
  int            mlr = 0;
  int            mlc = 0;
  bit            err_m = 1'b0;
  bit            last_acc = 1'b0;

  stream_trim #(.DATA_W(DW), .CHANNELS(CH), .IN_SIZE(IN), .OUT_SIZE(OUT), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .en(en), .row_off(row_off), .col_off(col_off),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_row_end(m_row_end), .m_last(m_last), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // One clock: check outputs against the model, then account for the edge's handshakes.
  task automatic tick();
    bit    acc, hs;
    beat_t act;
    int    r, c;
    #1;
    chk("m_valid", m_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("m_data", m_data, exp_q[0].d);
      chk("m_row_end", m_row_end, exp_q[0].re);
      chk("m_last", m_last, exp_q[0].la);
    end
    chk("s_ready", s_ready, en && (exp_q.size() == 0 || m_ready));
    chk("busy", busy, k != 0);
    chk("cfg_err", cfg_err, err_m);
    acc    = s_valid && s_ready;
    hs     = m_valid && m_ready;
    act.d  = m_data;
    act.re = m_row_end;
    act.la = m_last;
    @(posedge clk);
    if (!reset) begin
      exp_q.delete();
      k     = 0;
      err_m = 1'b0;
    end else begin
      if (hs) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_output: got %0h, expected no beat", act.d);
        end else begin
          void'(exp_q.pop_front());
          out_log.push_back(act);
        end
      end
      if (acc) begin
        if (k == 0) begin
          mlr   = (int'(row_off) > MAXO) ? MAXO : int'(row_off);
          mlc   = (int'(col_off) > MAXO) ? MAXO : int'(col_off);
          err_m = err_m || (int'(row_off) > MAXO) || (int'(col_off) > MAXO);
        end
        r = k / IN;
        c = k % IN;
        if (r >= mlr && r < mlr + OUT && c >= mlc && c < mlc + OUT)
          exp_q.push_back('{s_data, c == mlc + OUT - 1,
                            (c == mlc + OUT - 1) && (r == mlr + OUT - 1)});
        k = (k + 1) % (IN * IN);
      end
    end
    last_acc = acc && reset;
    @(negedge clk);
  endtask

  task automatic send_frame(input int ro, input int co, input bit stall, input int nbeats);
    int got = 0;
    int cyc = 0;
    for (int i = 0; i < IN * IN; i++)
      frame_data[i] = stall ? BW'($urandom) : BW'((i / IN) + (i % IN));
    row_off = IW'(ro);
    col_off = IW'(co);
    while (got < nbeats && cyc < 3000) begin
      s_data  = frame_data[got];
      s_valid = stall ? 1'($urandom_range(0, 3) != 0) : 1'b1;
      m_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      en      = !(stall && cyc >= 30 && cyc < 35);
      if (got > 0) begin
        row_off = IW'($urandom);
        col_off = IW'($urandom);
      end
      tick();
      if (last_acc) got++;
      cyc++;
    end
    if (got < nbeats) begin
      tests++;
      fails++;
      $display("FAIL frame_timeout: got %0d beats, expected %0d", got, nbeats);
    end
  endtask

  task automatic drain();
    s_valid = 1'b0;
    m_ready = 1'b1;
    en      = 1'b1;
    repeat (4) tick();
  endtask

  task automatic check_frame(input string name, input int base, input int first, input int last);
    int re_cnt = 0;
    int la_cnt = 0;
    chk({name, "_count"}, out_log.size() >= base + OUT * OUT, 1'b1);
    if (out_log.size() >= base + OUT * OUT) begin
      chk({name, "_first"}, out_log[base].d, BW'(first));
      chk({name, "_last"}, out_log[base + OUT * OUT - 1].d, BW'(last));
      chk({name, "_last_flag"}, out_log[base + OUT * OUT - 1].la, 1'b1);
      for (int i = 0; i < OUT * OUT; i++) begin
        if (out_log[base + i].re) re_cnt++;
        if (out_log[base + i].la) la_cnt++;
      end
      chk({name, "_row_ends"}, BW'(re_cnt), BW'(OUT));
      chk({name, "_last_count"}, BW'(la_cnt), BW'(1));
    end
  endtask

  initial begin
    int base, base_b, lr, lc, gi;
    reset = 1'b0; en = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    row_off = '0; col_off = '0; s_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, '0);
    chk("rst_m_row_end", m_row_end, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);

    base = out_log.size(); send_frame(3, 3, 1'b0, IN * IN); drain();
    check_frame("centre", base, 6, 18);
    chk("centre_cfg_err", cfg_err, 1'b0);

    base = out_log.size(); send_frame(0, 0, 1'b0, IN * IN); drain();
    check_frame("corner00", base, 0, 12);
    base = out_log.size(); send_frame(6, 6, 1'b0, IN * IN); drain();
    check_frame("corner66", base, 12, 24);

    base = out_log.size(); send_frame(10, 2, 1'b0, IN * IN); drain();
    check_frame("clamp", base, 8, 20);
    chk("clamp_cfg_err", cfg_err, 1'b1);
    base = out_log.size(); send_frame(3, 3, 1'b0, IN * IN); drain();
    check_frame("after_clamp", base, 6, 18);
    chk("sticky_cfg_err", cfg_err, 1'b1);

    base = out_log.size();
    send_frame(3, 3, 1'b0, IN * IN);
    base_b = out_log.size();
    send_frame(0, 0, 1'b0, IN * IN);
    drain();
    check_frame("b2b_a", base, 6, 18);
    check_frame("b2b_b", base + OUT * OUT, 0, 12);

    for (int f = 0; f < 3; f++) begin
      lr = $urandom_range(0, IN - 1);
      lc = $urandom_range(0, IN - 1);
      base = out_log.size();
      send_frame(lr, lc, 1'b1, IN * IN);
      drain();
      if (lr > MAXO) lr = MAXO;
      if (lc > MAXO) lc = MAXO;
      chk("bp_count", BW'(out_log.size() - base), BW'(OUT * OUT));
      gi = base;
      for (int r = lr; r < lr + OUT; r++)
        for (int c = lc; c < lc + OUT; c++) begin
          if (gi < out_log.size()) begin
            chk("bp_data", out_log[gi].d, frame_data[r * IN + c]);
            chk("bp_row_end", out_log[gi].re, c == lc + OUT - 1);
            chk("bp_last", out_log[gi].la, (c == lc + OUT - 1) && (r == lr + OUT - 1));
          end
          gi++;
        end
    end

    send_frame(5, 4, 1'b0, 20);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midrst_m_valid", m_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_cfg_err", cfg_err, 1'b0);
    base = out_log.size(); send_frame(3, 3, 1'b0, IN * IN); drain();
    check_frame("post_reset", base, 6, 18);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
